bcd_adder_4digits: RTL and testbench



---
 rtl/bcd_adder_4digits.sv | 111 +++++++++++
 tb/tb_bcd_adder_4digits.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_adder_4digits.sv
// rtl/bcd_adder_4digits.sv - registered 4-digit packed-BCD adder with carry in/out
//
// Purpose:
//   Computes a + b + cin over four packed-BCD digits through a single-cycle
//   ripple of per-digit decimal adders, then registers the result. The result
//   appears one clock after a qualified input; back-to-back inputs are allowed.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous reset, active low
//   in_valid   qualifies a, b, cin for capture this cycle
//   a, b       16-bit packed-BCD operands, digit 0 in bits [3:0]
//   cin        decimal carry into digit 0
//   sum        registered packed-BCD result
//   cout       registered decimal carry out of digit 3
//   out_valid  one-cycle pulse per accepted input
//   bcd_err    registered flag: an accepted operand digit was above 9
module bcd_adder_4digits (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        out_valid,
  output logic        bcd_err
);

  // One decimal digit: returns {carry_out, digit}. The raw 5-bit sum can reach
  // 31 for non-BCD digits (F+F+1); the +6 correction wraps modulo 16 so those
  // cases still give a deterministic digit.
  function automatic logic [4:0] digit_add(input logic [3:0] da,
                                           input logic [3:0] db,
                                           input logic       dc);
    logic [4:0] s;
    logic [4:0] adj;
    s   = {1'b0, da} + {1'b0, db} + {4'b0000, dc};
    adj = s + 5'd6;
    if (s > 5'd9) begin
      digit_add = {1'b1, adj[3:0]};
    end else begin
      digit_add = {1'b0, s[3:0]};
    end
  endfunction

  // A digit is out of range when it is 10..15: bit 3 set with bit 2 or bit 1.
  function automatic logic digit_bad(input logic [3:0] d);
    digit_bad = d[3] & (d[2] | d[1]);
  endfunction

  logic [4:0]  carry;
  logic [15:0] core_sum;
  logic        core_err;

  logic [15:0] sum_q,       sum_d;
  logic        cout_q,      cout_d;
  logic        out_valid_q, out_valid_d;
  logic        bcd_err_q,   bcd_err_d;

  // Carry ripples from digit 0 to digit 3 within the cycle.
  always_comb begin
    logic [4:0] r;
    carry    = 5'b00000;
    core_sum = 16'h0000;
    core_err = 1'b0;
    r        = 5'b00000;
    carry[0] = cin;
    for (int i = 0; i < 4; i++) begin
      r              = digit_add(a[4*i +: 4], b[4*i +: 4], carry[i]);
      core_sum[4*i +: 4] = r[3:0];
      carry[i+1]     = r[4];
      core_err       = core_err | digit_bad(a[4*i +: 4]) | digit_bad(b[4*i +: 4]);
    end
  end

  // Capture on in_valid, otherwise hold the last result; out_valid is a pulse.
  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    bcd_err_d   = bcd_err_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      sum_d       = core_sum;
      cout_d      = carry[4];
      bcd_err_d   = core_err;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q       <= 16'h0000;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      bcd_err_q   <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      bcd_err_q   <= bcd_err_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;
  assign bcd_err   = bcd_err_q;

endmodule

// File: tb/tb_bcd_adder_4digits.sv
// tb/tb_bcd_adder_4digits.sv - scoreboard bench for bcd_adder_4digits
module tb_bcd_adder_4digits;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        out_valid;
  logic        bcd_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        e;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  bcd_adder_4digits dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .cout     (cout),
    .out_valid(out_valid),
    .bcd_err  (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd_to_int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int v);
    logic [15:0] r = 16'h0000;
    int t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: plain decimal arithmetic for valid BCD; for non-BCD digits the
  // documented per-digit rule (sum > 9 -> add 6 mod 16, carry 1).
  function automatic exp_t ref_add(input logic [15:0] x, input logic [15:0] y,
                                   input logic ci, input string nm);
    exp_t r;
    bit   bad = 0;
    for (int i = 0; i < 4; i++)
      if (x[4*i +: 4] > 9 || y[4*i +: 4] > 9) bad = 1;
    r.name = nm;
    r.e    = bad;
    if (!bad) begin
      int tot = bcd_to_int(x) + bcd_to_int(y) + int'(ci);
      r.c = (tot >= 10000);
      r.s = int_to_bcd(tot % 10000);
    end else begin
      int c = int'(ci);
      for (int i = 0; i < 4; i++) begin
        int s = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + c;
        if (s > 9) begin
          r.s[4*i +: 4] = 4'((s + 6) % 16);
          c = 1;
        end else begin
          r.s[4*i +: 4] = 4'(s);
          c = 0;
        end
      end
      r.c = c[0];
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  // Drive one accepted addition with explicit expected values.
  task automatic issue_exp(input logic [15:0] x, input logic [15:0] y, input logic ci,
                           input logic [15:0] es, input logic ec, input logic ee,
                           input string nm);
    exp_t e;
    e.s = es; e.c = ec; e.e = ee; e.name = nm;
    a = x; b = y; cin = ci; in_valid = 1'b1;
    if (rst_n) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_ref(input logic [15:0] x, input logic [15:0] y, input logic ci);
    a = x; b = y; cin = ci; in_valid = 1'b1;
    if (rst_n) exp_q.push_back(ref_add(x, y, ci, "rand"));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Monitor: records what the edge should do, then checks at the falling edge.
  logic [15:0] held_s = 16'h0000;
  logic        held_c = 1'b0;
  logic        held_e = 1'b0;

  initial begin
    bit was_rst;
    bit was_acc;
    exp_t e;
    forever begin
      @(posedge clk);
      was_rst = !rst_n;
      was_acc = rst_n && in_valid;
      @(negedge clk);
      if (was_rst) begin
        held_s = 16'h0000; held_c = 1'b0; held_e = 1'b0;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'h0000);
        check("reset_cout_err", {30'd0, cout, bcd_err}, 32'd0);
      end else if (was_acc) begin
        check("out_valid_latency", 32'(out_valid), 32'd1);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL scoreboard_empty: actual=accepted required=expectation");
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_sum"}, 32'(sum), 32'(e.s));
          check({e.name, "_cout"}, 32'(cout), 32'(e.c));
          check({e.name, "_bcd_err"}, 32'(bcd_err), 32'(e.e));
          held_s = e.s; held_c = e.c; held_e = e.e;
        end
      end else begin
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("hold_result", {15'd0, sum, cout}, {15'd0, held_s, held_c});
        check("hold_bcd_err", 32'(bcd_err), 32'(held_e));
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h1234; cin = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle(2);

    issue_exp(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, "basic");
    issue_exp(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
    issue_exp(16'h4321, 16'h8765, 1'b1, 16'h3087, 1'b1, 1'b0, "carry_both");
    issue_exp(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "cin_only");
    issue_exp(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, "max");
    issue_exp(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "zero");

    issue_exp(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, "pre_hold");
    idle(3);

    // F+F+1 gives digit 5 carrying 1 into digit 1, so digit 1 becomes 1.
    issue_exp(16'h000F, 16'h000F, 1'b1, 16'h0015, 1'b0, 1'b1, "non_bcd");
    issue_exp(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, "err_clear");

    // Reset in the same cycle as an in_valid: that addition is lost.
    rst_n = 1'b0;
    issue_exp(16'h5555, 16'h4444, 1'b0, 16'h9999, 1'b0, 1'b0, "lost");
    rst_n = 1'b1;
    idle(2);

    for (int n = 0; n < 1200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle(1);
      end else if ($urandom_range(0, 19) == 0) begin
        issue_ref(16'($urandom), 16'($urandom), 1'($urandom));
      end else begin
        issue_ref(rand_bcd(), rand_bcd(), 1'($urandom));
      end
    end
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
